// File: rtl/vga_px_fetch.sv
// Framebuffer prefetch stage: streams 8-bit grey pixels from memory through a small
// word FIFO and presents one {g,g,g} pixel per px_tick, flagging underflow.
module vga_px_fetch #(
    parameter logic [31:0] FB_BASE    = 32'h0000_0000,
    parameter int unsigned IMG_PIXELS = 65536,
    parameter int unsigned DEPTH      = 4,
    parameter logic [23:0] ERR_COLOR  = 24'hFF00FF,
    parameter logic [23:0] BG_COLOR   = 24'h000000
) (
    input  logic        clk50MHz,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        px_tick,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [23:0] memPx,
    output logic        underflow
);

    localparam int unsigned WORDS = IMG_PIXELS / 4;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(2 * DEPTH + 1);
    localparam int WW = $clog2(WORDS + 1);
    localparam int XW = $clog2(IMG_PIXELS + 1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("vga_px_fetch: DEPTH must be a power of two >= 2");
    end
    if ((IMG_PIXELS == 0) || ((IMG_PIXELS % 4) != 0)) begin : g_bad_pixels
        $error("vga_px_fetch: IMG_PIXELS must be a non-zero multiple of 4");
    end
    if (FB_BASE[1:0] != 2'b00) begin : g_bad_base
        $error("vga_px_fetch: FB_BASE must be 4-byte aligned");
    end

    // Request side
    logic [31:0]   issue_addr;
    logic [WW-1:0] words_issued;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;

    // Word FIFO
    logic [31:0]   fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;

    // Pixel side
    logic [1:0]    byte_idx;
    logic [XW-1:0] px_count;

    logic          rsp_accept;
    logic          push;
    logic          pop;
    logic          issue;
    logic          fifo_empty;
    logic          frame_done;
    logic          consume;
    logic [SW-1:0] in_flight;
    logic [7:0]    head_byte;

    // A return with nothing outstanding belongs to no request of ours (e.g. one
    // lost across a reset) and is ignored entirely.
    assign rsp_accept = mem_rvalid && (outstanding != '0);
    assign push       = rsp_accept && (drop_cnt == '0) && !frame_start;

    assign fifo_empty = (fifo_count == '0);
    assign frame_done = (px_count == XW'(IMG_PIXELS));
    assign consume    = px_tick && !frame_start && !frame_done && !fifo_empty;
    assign pop        = consume && (byte_idx == 2'd3);

    assign in_flight  = SW'(fifo_count) + SW'(outstanding);
    assign issue      = !frame_start
                     && (words_issued < WW'(WORDS))
                     && (in_flight < SW'(DEPTH));

    assign head_byte  = fifo_mem[rd_ptr][{byte_idx, 3'b000} +: 8];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk50MHz or negedge rst) begin
        if (!rst) begin
            mem_rd       <= 1'b0;
            mem_addr     <= '0;
            issue_addr   <= FB_BASE;
            words_issued <= '0;
        end else begin
            mem_rd <= issue;
            if (frame_start) begin
                issue_addr   <= FB_BASE;
                words_issued <= '0;
            end else if (issue) begin
                mem_addr     <= issue_addr;
                issue_addr   <= issue_addr + 32'd4;
                words_issued <= words_issued + WW'(1);
            end
        end
    end

    // Reads in flight at a restart still come back; they are counted off and dropped.
    always_ff @(posedge clk50MHz or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(rsp_accept);
            if (frame_start) begin
                drop_cnt <= outstanding - CW'(rsp_accept);
            end else if (rsp_accept && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk50MHz or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (frame_start) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by the pointers
    // and count, so stale contents are never read.
    always_ff @(posedge clk50MHz) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

    always_ff @(posedge clk50MHz or negedge rst) begin
        if (!rst) begin
            memPx     <= '0;
            underflow <= 1'b0;
            byte_idx  <= '0;
            px_count  <= '0;
        end else if (frame_start) begin
            byte_idx <= '0;
            px_count <= '0;
        end else if (px_tick) begin
            if (frame_done) begin
                memPx <= BG_COLOR;
            end else if (fifo_empty) begin
                memPx     <= ERR_COLOR;
                underflow <= 1'b1;
            end else begin
                memPx    <= {3{head_byte}};
                px_count <= px_count + XW'(1);
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_px_fetch.sv
// Self-checking bench for vga_px_fetch: a full-size instance and an 8-pixel instance,
// each fed by a latency-2 memory model with stall, poison and stray-return controls.
module tb_vga_px_fetch;

    localparam int LAT = 2;

    typedef struct {
        int          inst;
        logic [31:0] data;
        int          ready;
    } req_t;

    typedef struct packed {
        logic [23:0] px;
        logic        uf;
    } vec_t;

    logic        clk50MHz = 1'b0;
    logic        rst;
    logic        fs      [2];
    logic        tk      [2];
    logic        stall   [2];
    logic        poison  [2];
    logic        inject  [2];
    logic        rvalid  [2] = '{1'b0, 1'b0};
    logic [31:0] rdata   [2] = '{32'h0, 32'h0};

    logic        b_rd,   s_rd;
    logic [31:0] b_addr, s_addr;
    logic [23:0] b_px,   s_px;
    logic        b_uf,   s_uf;

    int          rd_cnt   [2] = '{0, 0};
    logic [31:0] addr_log [2][256];
    req_t        mq [$];
    int          cyc = 0;

    logic [23:0] sb_px [$];
    logic        sb_uf [$];
    int          total = 0;
    int          bad   = 0;

    always #10 clk50MHz = ~clk50MHz;

    vga_px_fetch u_big (
        .clk50MHz   (clk50MHz),
        .rst        (rst),
        .frame_start(fs[0]),
        .px_tick    (tk[0]),
        .mem_rd     (b_rd),
        .mem_addr   (b_addr),
        .mem_rdata  (rdata[0]),
        .mem_rvalid (rvalid[0]),
        .memPx      (b_px),
        .underflow  (b_uf)
    );

    vga_px_fetch #(.IMG_PIXELS(8)) u_small (
        .clk50MHz   (clk50MHz),
        .rst        (rst),
        .frame_start(fs[1]),
        .px_tick    (tk[1]),
        .mem_rd     (s_rd),
        .mem_addr   (s_addr),
        .mem_rdata  (rdata[1]),
        .mem_rvalid (rvalid[1]),
        .memPx      (s_px),
        .underflow  (s_uf)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h4433_2211 + a * 32'h0101_0101;
    endfunction

    // Memory model: requests captured on the falling edge, answered in order LAT
    // falling edges later unless stalled; reset loses everything in flight.
    always @(negedge clk50MHz) begin
        logic        rd_v [2];
        logic [31:0] ad_v [2];
        req_t        r;
        rd_v[0] = b_rd;   rd_v[1] = s_rd;
        ad_v[0] = b_addr; ad_v[1] = s_addr;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            rvalid[i] = 1'b0;
            rdata[i]  = '0;
            if (inject[i]) begin
                rvalid[i] = 1'b1;
                rdata[i]  = 32'hBAD0_BAD0;
            end else if (!stall[i]) begin
                for (int j = 0; j < mq.size(); j++) begin
                    if (mq[j].inst == i) begin
                        if (mq[j].ready <= cyc) begin
                            rvalid[i] = 1'b1;
                            rdata[i]  = mq[j].data;
                            mq.delete(j);
                        end
                        break;
                    end
                end
            end
        end
        if (!rst) begin
            mq.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (rd_v[i]) begin
                    r.inst  = i;
                    r.data  = poison[i] ? 32'hDEAD_BEEF : mem_word(ad_v[i]);
                    r.ready = cyc + LAT;
                    mq.push_back(r);
                    addr_log[i][rd_cnt[i] % 256] = ad_v[i];
                    rd_cnt[i]++;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk50MHz);
        #1;
    endtask

    task automatic pulse_fs(input int i);
        fs[i] = 1'b1;
        @(negedge clk50MHz);
        #1;
        fs[i] = 1'b0;
    endtask

    // One-cycle tick; the expected pixel is queued now and checked once the DUT has registered it.
    task automatic tick(input int i, input logic [23:0] px, input logic uf, input string nm);
        logic [23:0] ep;
        logic        eu;
        sb_px.push_back(px);
        sb_uf.push_back(uf);
        tk[i] = 1'b1;
        @(negedge clk50MHz);
        #1;
        tk[i] = 1'b0;
        ep = sb_px.pop_front();
        eu = sb_uf.pop_front();
        check({nm, "_px"}, (i == 0) ? b_px : s_px, ep);
        check({nm, "_uf"}, (i == 0) ? b_uf : s_uf, eu);
    endtask

    initial begin
        vec_t        vt [8];
        int          base;
        int          n;
        logic [31:0] w;
        logic [7:0]  g;

        vt[0] = '{24'h111111, 1'b0};
        vt[1] = '{24'h222222, 1'b0};
        vt[2] = '{24'h333333, 1'b0};
        vt[3] = '{24'h444444, 1'b0};
        vt[4] = '{24'h151515, 1'b0};
        vt[5] = '{24'h262626, 1'b0};
        vt[6] = '{24'h373737, 1'b0};
        vt[7] = '{24'h484848, 1'b0};

        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fs[i] = 1'b0; tk[i] = 1'b0; stall[i] = 1'b0; poison[i] = 1'b0; inject[i] = 1'b0;
        end

        // Reset state
        repeat (3) @(negedge clk50MHz);
        #1;
        check("rst_mem_rd", b_rd, 0);
        check("rst_mem_addr", b_addr, 0);
        check("rst_memPx", b_px, 0);
        check("rst_underflow", b_uf, 0);

        // Basic stream after frame_start: addresses 0,4,8,12 and pixels in byte order
        rst = 1'b1;
        cycles(2);
        base = rd_cnt[0];
        pulse_fs(0);
        cycles(15);
        check("t1_nreq", rd_cnt[0] - base, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t1_addr%0d", k), addr_log[0][(base + k) % 256], 32'(4 * k));
        end
        for (int k = 0; k < 8; k++) begin
            tick(0, vt[k].px, vt[k].uf, $sformatf("t1_pix%0d", k));
        end
        cycles(15);

        // Memory stall: exactly DEPTH requests, then underflow on empty ticks
        stall[0] = 1'b1;
        base = rd_cnt[0];
        pulse_fs(0);
        cycles(20);
        check("t2_nreq", rd_cnt[0] - base, 4);
        check("t2_rd_idle", b_rd, 0);
        tick(0, 24'hFF00FF, 1'b1, "t2_empty0");
        tick(0, 24'hFF00FF, 1'b1, "t2_empty1");
        stall[0] = 1'b0;
        cycles(15);
        tick(0, 24'h111111, 1'b1, "t2_resume0");
        tick(0, 24'h222222, 1'b1, "t2_resume1");
        cycles(15);

        // Restart with three reads outstanding: those returns must be discarded
        stall[0]  = 1'b1;
        poison[0] = 1'b1;
        base = rd_cnt[0];
        pulse_fs(0);
        n = 0;
        while ((rd_cnt[0] - base < 3) && (n < 20)) begin
            @(negedge clk50MHz);
            #1;
            n++;
        end
        check("t3_three_issued", rd_cnt[0] - base, 3);
        fs[0]     = 1'b1;
        poison[0] = 1'b0;
        @(negedge clk50MHz);
        #1;
        fs[0]     = 1'b0;
        stall[0]  = 1'b0;
        cycles(15);
        check("t3_nreq", rd_cnt[0] - base, 7);
        check("t3_first_addr", addr_log[0][(base + 3) % 256], 0);
        for (int k = 0; k < 4; k++) begin
            tick(0, vt[k].px, 1'b1, $sformatf("t3_pix%0d", k));
        end

        // 8-pixel frame: two requests, then background colour past the end
        base = rd_cnt[1];
        pulse_fs(1);
        cycles(15);
        check("t4_nreq", rd_cnt[1] - base, 2);
        check("t4_addr0", addr_log[1][base % 256], 0);
        check("t4_addr1", addr_log[1][(base + 1) % 256], 4);
        for (int p = 0; p < 8; p++) begin
            w = mem_word(32'(4 * (p / 4)));
            g = w[8 * (p % 4) +: 8];
            tick(1, {3{g}}, 1'b0, $sformatf("t4_pix%0d", p));
        end
        tick(1, 24'h000000, 1'b0, "t4_bg0");
        tick(1, 24'h000000, 1'b0, "t4_bg1");
        check("t4_nreq_end", rd_cnt[1] - base, 2);

        // Reset mid-frame with reads outstanding, then a stray return after release
        stall[0] = 1'b1;
        base = rd_cnt[0];
        pulse_fs(0);
        n = 0;
        while ((rd_cnt[0] - base < 2) && (n < 20)) begin
            @(negedge clk50MHz);
            #1;
            n++;
        end
        check("t5_two_issued", rd_cnt[0] - base, 2);
        rst = 1'b0;
        #1;
        check("t5_rst_mem_rd", b_rd, 0);
        check("t5_rst_mem_addr", b_addr, 0);
        check("t5_rst_memPx", b_px, 0);
        check("t5_rst_underflow", b_uf, 0);
        check("t5_rst_small_px", s_px, 0);
        cycles(2);
        stall[0]  = 1'b0;
        inject[0] = 1'b1;
        @(negedge clk50MHz);
        #1;
        inject[0] = 1'b0;
        rst = 1'b1;
        cycles(15);
        for (int k = 0; k < 4; k++) begin
            tick(0, vt[k].px, 1'b0, $sformatf("t5_pix%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
